systolic_result_drain: RTL

- Receive end of the systolic array result interface: captures the flattened result matrix `c` on `out_valid` and serializes it one accumulator element per beat onto a downstream valid/ready stream.
- The array result port has no backpressure, so the block holds results in a two-entry ping-pong buffer.
- Exports `space_avail` so the upstream feeder can gate `in_valid` to the array.
- Flags any result lost to overflow.

---
 rtl/systolic_result_drain_if.sv | 35 +++
 rtl/systolic_result_drain.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/systolic_result_drain_if.sv
// Downstream element stream of the systolic result drain: one accumulator per beat,
// tagged with its matrix position, valid/ready handshake.
interface systolic_result_drain_if #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int ACC_WIDTH = 9
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;

    logic [ACC_WIDTH-1:0] m_data;
    logic [RW-1:0]        m_row;
    logic [CW-1:0]        m_col;
    logic                 m_last;
    logic                 m_valid;
    logic                 m_ready;

    modport master (
        output m_data,
        output m_row,
        output m_col,
        output m_last,
        output m_valid,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_row,
        input  m_col,
        input  m_last,
        input  m_valid,
        output m_ready
    );
endinterface

// File: rtl/systolic_result_drain.sv
// Captures systolic array result matrices into a ping-pong buffer and streams them out
// one element per beat. Define SYSTOLIC_DRAIN_COL_MAJOR_EN for column-major emission.
module systolic_result_drain #(
    parameter int ROWS      = 2,
    parameter int COLS      = 2,
    parameter int ACC_WIDTH = 9
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [ROWS*COLS*ACC_WIDTH-1:0] c,
    input  logic                          c_valid,
    output logic                          space_avail,
    systolic_result_drain_if.master       m,
    output logic                          overflow,
    input  logic                          clear_ovf
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int MW = ROWS * COLS * ACC_WIDTH;

    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t               state;
    logic [MW-1:0]        mat_buf [2];
    logic [1:0]           count;
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [RW-1:0]        row_q;
    logic [CW-1:0]        col_q;
    logic [ACC_WIDTH-1:0] data_q;
    logic                 last_q;
    logic                 valid_q;
    logic                 ovf_q;

    logic                 fire;
    logic                 at_last;
    logic                 release_beat;
    logic                 capture;
    logic                 drop;
    logic [1:0]           nxt_count;
    logic                 nxt_rd;
    logic [RW-1:0]        nxt_row;
    logic [CW-1:0]        nxt_col;
    logic                 nxt_valid;
    logic [MW-1:0]        src_mat;
    logic [ACC_WIDTH-1:0] nxt_data;

    assign fire         = valid_q && m.m_ready;
    assign at_last      = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign release_beat = fire && at_last;
    // A full buffer still accepts a matrix when the entry being read frees up this cycle.
    assign capture      = c_valid && ((count != 2'd2) || release_beat);
    assign drop         = c_valid && !capture;
    assign nxt_count    = count + {1'b0, capture} - {1'b0, release_beat};
    assign nxt_rd       = rd_ptr ^ release_beat;
    assign nxt_valid    = (nxt_count != 2'd0);

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_row = row_q;
        nxt_col = col_q;
        if (fire) begin
            if (at_last) begin
                nxt_row = '0;
                nxt_col = '0;
            end else begin
`ifdef SYSTOLIC_DRAIN_COL_MAJOR_EN
                if (row_q == ROW_LAST) begin
                    nxt_row = '0;
                    nxt_col = col_q + CW'(1);
                end else begin
                    nxt_row = row_q + RW'(1);
                end
`else
                if (col_q == COL_LAST) begin
                    nxt_col = '0;
                    nxt_row = row_q + RW'(1);
                end else begin
                    nxt_col = col_q + CW'(1);
                end
`endif
            end
        end
    end

    // Outputs are registered from next-state values, so a matrix written this cycle
    // into the entry about to be read is forwarded straight from c.
    always_comb begin
        src_mat  = mat_buf[nxt_rd];
        nxt_data = '0;
        if (capture && (wr_ptr == nxt_rd)) begin
            src_mat = c;
        end
        if (nxt_valid) begin
            nxt_data = src_mat[(int'(nxt_row) * COLS + int'(nxt_col)) * ACC_WIDTH +: ACC_WIDTH];
        end
    end

    // NOTE: result storage has no reset; only the control state below is reset,
    // and nothing reads an entry before it has been written.
    always_ff @(posedge clk) begin
        if (capture) begin
            mat_buf[wr_ptr] <= c;
        end
    end

    // NOTE: all sequential state uses non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            count   <= 2'd0;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            row_q   <= '0;
            col_q   <= '0;
            data_q  <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count  <= nxt_count;
            wr_ptr <= wr_ptr ^ capture;
            rd_ptr <= nxt_rd;
            row_q  <= nxt_row;
            col_q  <= nxt_col;

            case (state)
                IDLE: begin
                    if (nxt_valid) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (!nxt_valid) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            valid_q <= nxt_valid;
            data_q  <= nxt_data;
            last_q  <= nxt_valid && (nxt_row == ROW_LAST) && (nxt_col == COL_LAST);

            if (drop) begin
                ovf_q <= 1'b1;
            end else if (clear_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign space_avail = (count != 2'd2);
    assign overflow    = ovf_q;
    assign m.m_valid   = valid_q;
    assign m.m_data    = data_q;
    assign m.m_row     = row_q;
    assign m.m_col     = col_q;
    assign m.m_last    = last_q;
endmodule
